// File: rtl/div_arb_pkg.sv
// rtl/div_arb_pkg.sv - shared types and constants for the divider arbiter
package div_arb_pkg;

  localparam int DATA_W          = 64;
  localparam int DIV_LATENCY_DEF = 66;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Width of a down-counter that is loaded with lat-1 and counts to zero.
  function automatic int cnt_width(input int lat);
    if (lat <= 2) return 1;
    return $clog2(lat);
  endfunction

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// rtl/div_arbiter_rr_arbiter.sv - combinational round-robin grant picker
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  // Scan from the port just after the last winner, wrapping, first hit wins.
  always_comb begin
    int            k;
    logic [ID_W-1:0] k_idx;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    k       = 0;
    k_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k     = (int'(ptr_i) + i) % NUM_REQ;
      k_idx = ID_W'(k);
      if (!any_o && req_i[k_idx]) begin
        any_o          = 1'b1;
        grant_o[k_idx] = 1'b1;
        idx_o          = k_idx;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin front end sharing one divider; optional DIV_ARB_FASTPATH_EN
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_dividend_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_divisor_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [ID_W-1:0]           resp_id_o,
  output logic [DATA_W-1:0]         resp_quotient_o,
  output logic [DATA_W-1:0]         resp_remainder_o,
  output logic                      div_start_o,
  output logic [DATA_W-1:0]         div_dividend_o,
  output logic [DATA_W-1:0]         div_divisor_o,
  input  logic                      div_done_i,
  input  logic [DATA_W-1:0]         div_quotient_i,
  input  logic [DATA_W-1:0]         div_remainder_i,
  output logic                      busy_o
);

  localparam int CNT_W = cnt_width(DIV_LATENCY);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dividend_q, dividend_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic [DATA_W-1:0]   quot_q, quot_d;
  logic [DATA_W-1:0]   rem_q, rem_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic [DATA_W-1:0]   dvd_sel;
  logic [DATA_W-1:0]   dvs_sel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  assign dvd_sel = req_dividend_i[grant_idx*DATA_W +: DATA_W];
  assign dvs_sel = req_divisor_i[grant_idx*DATA_W +: DATA_W];

  // Accept is only offered in IDLE and never while reset is asserted.
  assign req_ready_o      = (state_q == IDLE && reset_n_i) ? grant : '0;
  assign resp_valid_o     = (state_q == RESP);
  assign div_start_o      = (state_q == ISSUE);
  assign busy_o           = (state_q != IDLE);
  assign resp_id_o        = id_q;
  assign resp_quotient_o  = quot_q;
  assign resp_remainder_o = rem_q;
  assign div_dividend_o   = dividend_q;
  assign div_divisor_o    = divisor_q;

  // Next-state, counter and datapath register updates for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          id_d       = grant_idx;
          dividend_d = dvd_sel;
          divisor_d  = dvs_sel;
`ifdef DIV_ARB_FASTPATH_EN
          // Trivial divisors are answered locally without waking the divider.
          if (dvs_sel == '0) begin
            quot_d  = '1;
            rem_d   = dvd_sel;
            state_d = RESP;
          end else if (dvs_sel == DATA_W'(1)) begin
            quot_d  = dvd_sel;
            rem_d   = '0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(DIV_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // A done seen before the counter expires is left over from the last op.
        if (cnt_q == '0) begin
          if (div_done_i) begin
            quot_d  = div_quotient_i;
            rem_d   = div_remainder_i;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          rr_ptr_d = id_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed self-checking bench for div_arbiter
module tb_div_arbiter;

  localparam int NR = 4;
  localparam int DL = 66;
`ifdef DIV_ARB_FASTPATH_EN
  localparam int FAST_LAT    = 1;
  localparam int FAST_STARTS = 0;
`else
  localparam int FAST_LAT    = DL + 2;
  localparam int FAST_STARTS = 1;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*64-1:0] req_dividend = '0;
  logic [NR*64-1:0] req_divisor = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [1:0]      resp_id;
  logic [63:0]     resp_q;
  logic [63:0]     resp_r;
  logic            div_start;
  logic [63:0]     div_dvd;
  logic [63:0]     div_dvs;
  logic            busy;
  logic            done_m = 1'b0;
  logic [63:0]     q_m = '0;
  logic [63:0]     r_m = '0;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int ready_cnt = 0;
  int multi_cnt = 0;
  int dcnt = 0;
  int extra = 0;
  bit force_done = 1'b0;
  logic [63:0] res_q = '0;
  logic [63:0] res_r = '0;

  always #5 clk = ~clk;

  div_arbiter #(.NUM_REQ(NR), .ID_W(2), .DIV_LATENCY(DL)) dut (
    .clk              (clk),
    .reset_n_i        (reset_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_dividend_i   (req_dividend),
    .req_divisor_i    (req_divisor),
    .resp_valid_o     (resp_valid),
    .resp_ready_i     (resp_ready),
    .resp_id_o        (resp_id),
    .resp_quotient_o  (resp_q),
    .resp_remainder_o (resp_r),
    .div_start_o      (div_start),
    .div_dividend_o   (div_dvd),
    .div_divisor_o    (div_dvs),
    .div_done_i       (done_m),
    .div_quotient_i   (q_m),
    .div_remainder_i  (r_m),
    .busy_o           (busy)
  );

  function automatic logic [63:0] mdiv(input logic [63:0] a, input logic [63:0] b);
    if (b == 64'd0) return '1;
    return $signed(a) / $signed(b);
  endfunction

  function automatic logic [63:0] mrem(input logic [63:0] a, input logic [63:0] b);
    if (b == 64'd0) return a;
    return $signed(a) % $signed(b);
  endfunction

  // Divider model: result bus is garbage until DL cycles after start, done stays high afterwards.
  always @(negedge clk) begin
    if (!reset_n) begin
      dcnt   <= 0;
      done_m <= 1'b0;
    end else if (div_start) begin
      res_q  <= mdiv(div_dvd, div_dvs);
      res_r  <= mrem(div_dvd, div_dvs);
      dcnt   <= DL + extra;
      done_m <= force_done;
      q_m    <= 64'hDEAD_BEEF_DEAD_BEEF;
      r_m    <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        done_m <= 1'b1;
        q_m    <= res_q;
        r_m    <= res_r;
      end
    end
  end

  // Event counters for start pulses and accepts.
  always @(negedge clk) begin
    if (reset_n) begin
      if (div_start) start_cnt <= start_cnt + 1;
      if (req_ready != '0) ready_cnt <= ready_cnt + 1;
      if ($countones(req_ready) > 1) multi_cnt <= multi_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [63:0] a, input logic [63:0] b);
    req_dividend[k*64 +: 64] = a;
    req_divisor[k*64 +: 64]  = b;
  endtask

  task automatic wait_resp(input bit clear_valid, output int lat);
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (n == 1 && clear_valid) req_valid = '0;
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = '1;
    tick();
    tick();
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++;
    if ({busy, resp_valid, div_start} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000", {busy, resp_valid, div_start});
    end
    checks++;
    if ({div_dvd, div_dvs, resp_q, resp_r, resp_id} !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h %h exp all zero", div_dvd, div_dvs, resp_q, resp_r, resp_id);
    end
    req_valid = '0;
    reset_n   = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int lat;
    int s0;
    int r0;
    s0 = start_cnt;
    r0 = ready_cnt;
    set_op(0, 64'd100, 64'd7);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    wait_resp(1'b1, lat);
    checks++;
    if (lat !== DL + 2) begin errors++; $display("FAIL single_latency got %0d exp %0d", lat, DL + 2); end
    checks++;
    if ({resp_id, resp_q, resp_r} !== {2'd0, 64'd14, 64'd2}) begin
      errors++; $display("FAIL single_data got id %0d q %0d r %0d exp id 0 q 14 r 2", resp_id, resp_q, resp_r);
    end
    checks++;
    if (start_cnt - s0 !== 1 || ready_cnt - r0 !== 1) begin
      errors++; $display("FAIL single_pulses got start %0d ready %0d exp 1 1", start_cnt - s0, ready_cnt - r0);
    end
    drain();
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_release got %b exp 0", resp_valid); end
  endtask

  task automatic test_round_robin();
    logic [63:0] exp_q [4] = '{64'd6, 64'd10, 64'd13, 64'd16};
    logic [63:0] exp_r [4] = '{64'd2, 64'd0, 64'd1, 64'd2};
    int lat;
    int r0;
    int e;
    pulse_reset();
    for (int k = 0; k < NR; k++) set_op(k, 64'(20 + 10 * k), 64'd3);
    r0 = ready_cnt;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e = i % NR;
      #1;
      checks++;
      if (req_ready !== 4'(1 << e)) begin errors++; $display("FAIL rr_grant_%0d got %b exp %b", i, req_ready, 4'(1 << e)); end
      wait_resp(1'b0, lat);
      checks++;
      if (lat !== DL + 2) begin errors++; $display("FAIL rr_latency_%0d got %0d exp %0d", i, lat, DL + 2); end
      checks++;
      if ({resp_id, resp_q, resp_r} !== {2'(e), exp_q[e], exp_r[e]}) begin
        errors++; $display("FAIL rr_data_%0d got id %0d q %0d r %0d exp id %0d q %0d r %0d", i, resp_id, resp_q, resp_r, e, exp_q[e], exp_r[e]);
      end
      if (i == 4) req_valid = '0;
      tick();
    end
    resp_ready = 1'b0;
    checks++;
    if (ready_cnt - r0 !== 5 || multi_cnt !== 0) begin
      errors++; $display("FAIL rr_accepts got %0d multi %0d exp 5 multi 0", ready_cnt - r0, multi_cnt);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    set_op(1, -64'sd100, 64'd7);
    set_op(2, 64'd7, 64'd2);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant got %b exp 0010", req_ready); end
    wait_resp(1'b1, lat);
    req_valid = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({resp_valid, resp_id, resp_q, resp_r, req_ready} !== {1'b1, 2'd1, -64'sd14, -64'sd2, 4'b0000}) begin
        errors++; $display("FAIL bp_hold_%0d got v %b id %0d q %h r %h rdy %b exp v 1 id 1 q -14 r -2 rdy 0000", c, resp_valid, resp_id, resp_q, resp_r, req_ready);
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if ({resp_valid, req_ready} !== {1'b0, 4'b0100}) begin
      errors++; $display("FAIL bp_next_grant got v %b rdy %b exp v 0 rdy 0100", resp_valid, req_ready);
    end
    wait_resp(1'b1, lat);
    checks++;
    if ({resp_id, resp_q, resp_r} !== {2'd2, 64'd3, 64'd1}) begin
      errors++; $display("FAIL bp_second got id %0d q %0d r %0d exp id 2 q 3 r 1", resp_id, resp_q, resp_r);
    end
    drain();
  endtask

  task automatic test_early_done();
    int lat;
    force_done = 1'b1;
    set_op(3, 64'd81, 64'd9);
    req_valid = 4'b1000;
    wait_resp(1'b1, lat);
    force_done = 1'b0;
    checks++;
    if (lat !== DL + 2) begin errors++; $display("FAIL early_done_latency got %0d exp %0d", lat, DL + 2); end
    checks++;
    if ({resp_id, resp_q, resp_r} !== {2'd3, 64'd9, 64'd0}) begin
      errors++; $display("FAIL early_done_data got id %0d q %h r %h exp id 3 q 9 r 0", resp_id, resp_q, resp_r);
    end
    drain();
  endtask

  task automatic test_late_done();
    int lat;
    extra = 5;
    set_op(0, 64'd1000, 64'd10);
    req_valid = 4'b0001;
    wait_resp(1'b1, lat);
    extra = 0;
    checks++;
    if (lat !== DL + 2 + 5) begin errors++; $display("FAIL late_done_latency got %0d exp %0d", lat, DL + 7); end
    checks++;
    if ({resp_id, resp_q, resp_r} !== {2'd0, 64'd100, 64'd0}) begin
      errors++; $display("FAIL late_done_data got id %0d q %0d r %0d exp id 0 q 100 r 0", resp_id, resp_q, resp_r);
    end
    drain();
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    set_op(1, 64'd50, 64'd5);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    repeat (20) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({busy, resp_valid, div_start} !== 3'b000) begin
      errors++; $display("FAIL abort_wait got busy %b v %b start %b exp 000", busy, resp_valid, div_start);
    end
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (resp_valid || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_wait_quiet got %0d active cycles exp 0", seen); end
    set_op(0, 64'd9, 64'd4);
    req_valid = 4'b0001;
    wait_resp(1'b1, lat);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({busy, resp_valid, resp_q} !== {1'b0, 1'b0, 64'd0}) begin
      errors++; $display("FAIL abort_resp got busy %b v %b q %h exp 0 0 0", busy, resp_valid, resp_q);
    end
    set_op(0, 64'd9, 64'd4);
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL abort_regrant got %b exp 0001", req_ready); end
    wait_resp(1'b1, lat);
    checks++;
    if ({resp_id, resp_q, resp_r} !== {2'd0, 64'd2, 64'd1}) begin
      errors++; $display("FAIL abort_regrant_data got id %0d q %0d r %0d exp id 0 q 2 r 1", resp_id, resp_q, resp_r);
    end
    drain();
  endtask

  task automatic test_fastpath();
    int lat;
    int s0;
    s0 = start_cnt;
    set_op(1, 64'd55, 64'd0);
    req_valid = 4'b0010;
    wait_resp(1'b1, lat);
    checks++;
    if (lat !== FAST_LAT) begin errors++; $display("FAIL fast_div0_latency got %0d exp %0d", lat, FAST_LAT); end
    checks++;
    if ({resp_id, resp_q, resp_r} !== {2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd55}) begin
      errors++; $display("FAIL fast_div0_data got id %0d q %h r %0d exp id 1 q ffffffffffffffff r 55", resp_id, resp_q, resp_r);
    end
    checks++;
    if (start_cnt - s0 !== FAST_STARTS) begin errors++; $display("FAIL fast_div0_starts got %0d exp %0d", start_cnt - s0, FAST_STARTS); end
    drain();
    s0 = start_cnt;
    set_op(2, 64'd55, 64'd1);
    req_valid = 4'b0100;
    wait_resp(1'b1, lat);
    checks++;
    if (lat !== FAST_LAT) begin errors++; $display("FAIL fast_div1_latency got %0d exp %0d", lat, FAST_LAT); end
    checks++;
    if ({resp_id, resp_q, resp_r} !== {2'd2, 64'd55, 64'd0}) begin
      errors++; $display("FAIL fast_div1_data got id %0d q %0d r %0d exp id 2 q 55 r 0", resp_id, resp_q, resp_r);
    end
    checks++;
    if (start_cnt - s0 !== FAST_STARTS) begin errors++; $display("FAIL fast_div1_starts got %0d exp %0d", start_cnt - s0, FAST_STARTS); end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_early_done();
    test_late_done();
    test_reset_abort();
    test_fastpath();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after 500000 time units, exp test sequence to complete");
    $fatal(1, "watchdog");
  end

endmodule
